mem_access: RTL and testbench
=============================

# mem_access

Memory-access stage of the core: the responder for the execute stage's load/store results. It takes the executed operation, address/ALU result, store data and destination register. It runs a valid/ready transaction against the data memory, aligns and sign/zero-extends load data, and hands a writeback result to the register-file stage. Non-memory operations pass straight through with one cycle of latency.

## Interface
Parameters:
- XLEN, 32, datapath width
- TIMEOUT, 16, maximum cycles in REQ waiting for mem_ready before aborting (≥1)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  execute-stage result valid this cycle
- in_ready  out  1  stage can accept; high only in IDLE
- operation  in  12  funct concatenated with opcode; opcode = [6:0], funct3 = [9:7]
- exec_out  in  XLEN  ALU result / effective byte address
- content_rs2  in  XLEN  store data
- address_rd  in  5  destination register
- mem_req  out  1  memory request, held until accepted
- mem_we  out  1  write request
- mem_addr  out  XLEN  word address (exec_out with [1:0] = 0)
- mem_wdata  out  XLEN  lane-positioned store data
- mem_wstrb  out  4  byte-lane enables, bit 3 = lane [31:24]
- mem_ready  in  1  memory accepts/completes the request this cycle
- mem_rdata  in  XLEN  read word, valid when mem_ready
- out_valid  out  1  one-cycle result pulse
- out_data  out  XLEN  writeback value
- out_rd  out  5  writeback register
- out_we  out  1  register write enable
- stall  out  1  freeze upstream; equals ~in_ready
- bus_err  out  1  one-cycle pulse with out_valid on timeout
- misalign  out  1  one-cycle pulse with out_valid on misaligned access (MISALIGN_TRAP_EN only)

## Operation
- Byte lanes: byte offset k (exec_out[1:0]) maps to bits [31-8k -: 8]. Halfword offset 0 maps to [31:16]; offset 2 maps to [15:0].
- Loads (opcode 0000011), by funct3:
  - 000 LB: sign-extend the selected byte
  - 001 LH: sign-extend the selected halfword
  - 010 LW: whole word
  - 100 LBU: zero-extend the selected byte
  - 101 LHU: zero-extend the selected halfword
- Stores (opcode 0100011), by funct3:
  - 000 SB: byte replicated into all lanes, one strobe bit
  - 001 SH: halfword replicated into both halves, two strobe bits
  - 010 SW: whole word, strobe 1111
- Other funct3 values under a load/store opcode are treated as non-memory.
- FSM states: IDLE, REQ, RESP.
  - IDLE: on in_valid, latch all inputs.
    - Memory op: go to REQ.
    - Otherwise: next cycle out_valid=1, out_data=exec_out, out_rd=address_rd, out_we=(address_rd≠0); stay in IDLE. Back-to-back pass-through is allowed.
  - REQ: mem_req=1, outputs stable, timeout counter increments.
    - mem_ready=1: capture and extend load data, go to RESP.
    - Counter reaches TIMEOUT without mem_ready: drop mem_req, go to RESP with bus_err set.
  - RESP: out_valid=1 for one cycle, then IDLE.
    - Load: out_we=(address_rd≠0 and no error).
    - Store: out_data=0, out_we=0.
    - Error: out_data=0, out_we=0.
- x0 is never written; out_rd still reports the latched value.
- in_valid while not IDLE is ignored; upstream must hold its data while stall=1.

## Timing
- Reset, asynchronous and active-low. State goes to IDLE and every output is 0 (in_ready=1 and stall=0 once reset deasserts). The timeout counter clears.
- Reset asserted mid-REQ drops mem_req immediately. The pending transaction is lost and produces no out_valid.
- Pass-through latency: 1 cycle from the accepting edge.
- Memory-op latency: 2 + w cycles, where w is the number of REQ cycles before mem_ready. Minimum is 2.
- mem_req and mem_* outputs change only on REQ entry/exit. mem_ready sampled outside REQ is ignored.
- mem_ready arriving in the same cycle the counter hits TIMEOUT is treated as success; no bus_err.
- The timeout counter is ceil(log2(TIMEOUT+1)) bits and saturates; it does not wrap.

## Configuration
- MISALIGN_TRAP_EN defined: misaligned accesses (halfword with addr[0]=1; word with addr[1:0]≠0) skip REQ. IDLE goes directly to RESP with misalign=1, out_we=0, out_data=0, mem_req never asserted.
- Not defined: misalign is tied to 0. Halfword accesses ignore addr[0]; word accesses ignore addr[1:0].

## Test plan
- ADD pass-through: exec_out=0x0000_0005, rd=3 → next cycle out_valid=1, out_data=5, out_we=1; in_ready stays 1.
- LB: addr 0x101, mem_rdata=0x12F4_5678 with mem_ready in the first REQ cycle → out_data=0xFFFF_FFF4 two cycles after accept; mem_addr=0x100.
- LHU: addr 0x102, mem_rdata=0xAAAA_8001, mem_ready after 3 wait cycles → out_data=0x0000_8001 at cycle 5; stall high for cycles 1–4.
- SB: addr 0x203, rs2=0x0000_00AB → mem_we=1, mem_wstrb=0001, mem_wdata=0xABAB_ABAB; out_valid with out_we=0.
- Timeout: LW, mem_ready held 0 for TIMEOUT=16 cycles → mem_req drops, out_valid and bus_err pulse together, out_we=0; reset asserted during a repeat of this test clears everything with no out_valid.
- MISALIGN_TRAP_EN: LW at 0x102 → no mem_req, misalign=1 and out_valid=1 one cycle after accept. Without the macro, the same access reads word 0x100.

Source files
------------

// File: rtl/mem_access.sv
// Load/store stage: drives a valid/ready data-memory transaction, aligns load data, forwards ALU results.
// Optional build macro MISALIGN_TRAP_EN: misaligned halfword/word accesses trap instead of touching memory.
module mem_access #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [11:0]     operation,
  input  logic [XLEN-1:0] exec_out,
  input  logic [XLEN-1:0] content_rs2,
  input  logic [4:0]      address_rd,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            out_valid,
  output logic [XLEN-1:0] out_data,
  output logic [4:0]      out_rd,
  output logic            out_we,
  output logic            stall,
  output logic            bus_err,
  output logic            misalign
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]      state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic            ld_q;
  logic            mem_req_q, mem_we_q;
  logic [XLEN-1:0] mem_addr_q, mem_wdata_q;
  logic [3:0]      mem_wstrb_q;
  logic            out_valid_q, out_we_q, bus_err_q, misalign_q;
  logic [XLEN-1:0] out_data_q;
  logic [4:0]      out_rd_q;

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic            is_ld, is_st, is_mis, trap;
  logic [XLEN-1:0] wdata_d, ld_ext_d;
  logic [3:0]      wstrb_d;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic            timed_out;
  logic            unused_funct_hi;

  assign opcode          = operation[6:0];
  assign f3              = operation[9:7];
  assign unused_funct_hi = ^operation[11:10];

  assign is_ld  = (opcode == 7'b0000011) &&
                  (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b100 || f3 == 3'b101);
  assign is_st  = (opcode == 7'b0100011) && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010);
  assign is_mis = (f3[1:0] == 2'b01 && exec_out[0]) || (f3[1:0] == 2'b10 && exec_out[1:0] != 2'b00);

`ifdef MISALIGN_TRAP_EN
  assign trap     = is_mis;
  assign misalign = misalign_q;
`else
  assign trap     = 1'b0;
  assign misalign = 1'b0;
`endif

  // Byte offset 0 is the most significant lane; strobe bit 3 follows it.
  always_comb begin
    wdata_d = '0;
    wstrb_d = 4'b0000;
    if (is_st) begin
      case (f3[1:0])
        2'b00: begin
          wdata_d = {4{content_rs2[7:0]}};
          wstrb_d = 4'b1000 >> exec_out[1:0];
        end
        2'b01: begin
          wdata_d = {2{content_rs2[15:0]}};
          wstrb_d = exec_out[1] ? 4'b0011 : 4'b1100;
        end
        default: begin
          wdata_d = content_rs2;
          wstrb_d = 4'b1111;
        end
      endcase
    end
  end

  always_comb begin
    case (off_q)
      2'd0:    ld_byte = mem_rdata[31:24];
      2'd1:    ld_byte = mem_rdata[23:16];
      2'd2:    ld_byte = mem_rdata[15:8];
      default: ld_byte = mem_rdata[7:0];
    endcase
    ld_half = off_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    case (f3_q)
      3'b000:  ld_ext_d = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext_d = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b100:  ld_ext_d = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  ld_ext_d = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_ext_d = mem_rdata;
    endcase
  end

  // A ready arriving on the final allowed cycle wins over the timeout.
  assign timed_out = (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      f3_q        <= '0;
      off_q       <= '0;
      ld_q        <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      out_valid_q <= 1'b0;
      out_we_q    <= 1'b0;
      out_data_q  <= '0;
      out_rd_q    <= '0;
      bus_err_q   <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      bus_err_q   <= 1'b0;
      misalign_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            f3_q     <= f3;
            off_q    <= exec_out[1:0];
            ld_q     <= is_ld;
            out_rd_q <= address_rd;
            if ((is_ld || is_st) && trap) begin
              state_q     <= S_RESP;
              out_valid_q <= 1'b1;
              misalign_q  <= 1'b1;
              out_data_q  <= '0;
              out_we_q    <= 1'b0;
            end else if (is_ld || is_st) begin
              state_q     <= S_REQ;
              cnt_q       <= '0;
              mem_req_q   <= 1'b1;
              mem_we_q    <= is_st;
              mem_addr_q  <= {exec_out[XLEN-1:2], 2'b00};
              mem_wdata_q <= wdata_d;
              mem_wstrb_q <= wstrb_d;
            end else begin
              out_valid_q <= 1'b1;
              out_data_q  <= exec_out;
              out_we_q    <= (address_rd != 5'd0);
            end
          end
        end
        S_REQ: begin
          if (cnt_q != CW'(TIMEOUT)) cnt_q <= cnt_q + 1'b1;
          if (mem_ready || timed_out) begin
            state_q     <= S_RESP;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            out_valid_q <= 1'b1;
            bus_err_q   <= ~mem_ready;
            out_data_q  <= (mem_ready && ld_q) ? ld_ext_d : '0;
            out_we_q    <= mem_ready && ld_q && (out_rd_q != 5'd0);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = reset && (state_q == S_IDLE);
  assign stall     = reset && (state_q != S_IDLE);
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_rd    = out_rd_q;
  assign out_we    = out_we_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: pass-through, loads, stores, timeout, reset abort, misalignment.
module tb_mem_access;
  localparam int XLEN = 32;
  localparam int TO   = 16;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_ALU = 7'b0110011;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [11:0]     operation = '0;
  logic [XLEN-1:0] exec_out = '0;
  logic [XLEN-1:0] content_rs2 = '0;
  logic [4:0]      address_rd = '0;
  logic            mem_req, mem_we;
  logic [XLEN-1:0] mem_addr, mem_wdata;
  logic [3:0]      mem_wstrb;
  logic            mem_ready = 1'b0;
  logic [XLEN-1:0] mem_rdata = '0;
  logic            out_valid;
  logic [XLEN-1:0] out_data;
  logic [4:0]      out_rd;
  logic            out_we, stall, bus_err, misalign;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .operation(operation), .exec_out(exec_out), .content_rs2(content_rs2),
    .address_rd(address_rd), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .out_valid(out_valid), .out_data(out_data), .out_rd(out_rd),
    .out_we(out_we), .stall(stall), .bus_err(bus_err), .misalign(misalign)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one operation for exactly one accepting edge.
  task automatic issue(input logic [2:0] f3, input logic [6:0] opc, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] rd);
    operation   = {2'b00, f3, opc};
    exec_out    = a;
    content_rs2 = d;
    address_rd  = rd;
    in_valid    = 1'b1;
    tick();
    in_valid    = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    checks++; if ({out_valid, mem_req, in_ready, stall, bus_err, misalign, out_we} !== 7'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=0000000", {out_valid, mem_req, in_ready, stall, bus_err, misalign, out_we}); end
    checks++; if (out_data !== 32'h0 || mem_addr !== 32'h0 || mem_wstrb !== 4'h0) begin
      failures++; $display("FAIL reset_data out_data=%h mem_addr=%h strb=%b exp=0", out_data, mem_addr, mem_wstrb); end
    #4 reset = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1 || stall !== 1'b0) begin
      failures++; $display("FAIL reset_release in_ready=%b stall=%b exp=1/0", in_ready, stall); end
    tick();
  endtask

  task automatic test_passthrough();
    issue(3'b000, OP_ALU, 32'h0000_0005, 32'h0, 5'd3);
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h5 || out_we !== 1'b1 || out_rd !== 5'd3) begin
      failures++; $display("FAIL add_pass valid=%b data=%h we=%b rd=%0d exp=1/5/1/3", out_valid, out_data, out_we, out_rd); end
    checks++; if (in_ready !== 1'b1 || mem_req !== 1'b0) begin
      failures++; $display("FAIL add_ready in_ready=%b mem_req=%b exp=1/0", in_ready, mem_req); end
    tick();
    checks++; if (out_valid !== 1'b0) begin
      failures++; $display("FAIL add_pulse out_valid=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    operation = {2'b00, 3'b000, OP_ALU}; exec_out = 32'h11; address_rd = 5'd0; in_valid = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h11 || out_we !== 1'b0 || out_rd !== 5'd0) begin
      failures++; $display("FAIL b2b_x0 valid=%b data=%h we=%b rd=%0d exp=1/11/0/0", out_valid, out_data, out_we, out_rd); end
    exec_out = 32'h22; address_rd = 5'd7;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h22 || out_we !== 1'b1 || out_rd !== 5'd7) begin
      failures++; $display("FAIL b2b_second valid=%b data=%h we=%b rd=%0d exp=1/22/1/7", out_valid, out_data, out_we, out_rd); end
    tick();
  endtask

  task automatic test_ignore_ready_idle();
    mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    checks++; if (out_valid !== 1'b0 || mem_req !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL idle_ready valid=%b req=%b in_ready=%b exp=0/0/1", out_valid, mem_req, in_ready); end
    mem_ready = 1'b0;
  endtask

  task automatic test_lb();
    issue(3'b000, OP_LD, 32'h0000_0101, 32'h0, 5'd5);
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100 || stall !== 1'b1) begin
      failures++; $display("FAIL lb_req req=%b we=%b addr=%h stall=%b exp=1/0/100/1", mem_req, mem_we, mem_addr, stall); end
    mem_ready = 1'b1; mem_rdata = 32'h12F4_5678;
    tick();
    mem_ready = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'hFFFF_FFF4 || out_we !== 1'b1 || out_rd !== 5'd5) begin
      failures++; $display("FAIL lb_data valid=%b data=%h we=%b rd=%0d exp=1/fffffff4/1/5", out_valid, out_data, out_we, out_rd); end
    checks++; if (mem_req !== 1'b0) begin
      failures++; $display("FAIL lb_req_drop mem_req=%b exp=0", mem_req); end
    tick();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL lb_idle in_ready=%b valid=%b exp=1/0", in_ready, out_valid); end
  endtask

  task automatic test_lh();
    issue(3'b001, OP_LD, 32'h0000_0100, 32'h0, 5'd2);
    mem_ready = 1'b1; mem_rdata = 32'h8001_1234;
    tick();
    mem_ready = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'hFFFF_8001) begin
      failures++; $display("FAIL lh_data valid=%b data=%h exp=1/ffff8001", out_valid, out_data); end
    tick();
  endtask

  task automatic test_lhu();
    issue(3'b101, OP_LD, 32'h0000_0102, 32'h0, 5'd9);
    for (int c = 1; c <= 4; c++) begin
      checks++; if (stall !== 1'b1 || out_valid !== 1'b0 || mem_req !== 1'b1) begin
        failures++; $display("FAIL lhu_wait cycle=%0d stall=%b valid=%b req=%b exp=1/0/1", c, stall, out_valid, mem_req); end
      if (c == 4) begin mem_ready = 1'b1; mem_rdata = 32'hAAAA_8001; end
      tick();
    end
    mem_ready = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h0000_8001 || out_we !== 1'b1) begin
      failures++; $display("FAIL lhu_data valid=%b data=%h we=%b exp=1/00008001/1", out_valid, out_data, out_we); end
    tick();
  endtask

  task automatic test_sb();
    issue(3'b000, OP_ST, 32'h0000_0203, 32'h0000_00AB, 5'd4);
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wstrb !== 4'b0001 ||
                  mem_wdata !== 32'hABAB_ABAB || mem_addr !== 32'h200) begin
      failures++; $display("FAIL sb_req req=%b we=%b strb=%b wdata=%h addr=%h exp=1/1/0001/abababab/200",
                           mem_req, mem_we, mem_wstrb, mem_wdata, mem_addr); end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_we !== 1'b0 || out_data !== 32'h0) begin
      failures++; $display("FAIL sb_resp valid=%b we=%b data=%h exp=1/0/0", out_valid, out_we, out_data); end
    tick();
  endtask

  task automatic test_sh();
    issue(3'b001, OP_ST, 32'h0000_0200, 32'h0000_BEEF, 5'd4);
    checks++; if (mem_wstrb !== 4'b1100 || mem_wdata !== 32'hBEEF_BEEF) begin
      failures++; $display("FAIL sh_req strb=%b wdata=%h exp=1100/beefbeef", mem_wstrb, mem_wdata); end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    issue(3'b010, OP_LD, 32'h0000_0300, 32'h0, 5'd6);
    for (int c = 1; c <= TO; c++) begin
      checks++; if (mem_req !== 1'b1 || out_valid !== 1'b0) begin
        failures++; $display("FAIL to_wait cycle=%0d req=%b valid=%b exp=1/0", c, mem_req, out_valid); end
      tick();
    end
    checks++; if (mem_req !== 1'b0 || out_valid !== 1'b1 || bus_err !== 1'b1 || out_we !== 1'b0 || out_data !== 32'h0) begin
      failures++; $display("FAIL to_resp req=%b valid=%b err=%b we=%b data=%h exp=0/1/1/0/0",
                           mem_req, out_valid, bus_err, out_we, out_data); end
    tick();
    checks++; if (bus_err !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL to_after err=%b in_ready=%b exp=0/1", bus_err, in_ready); end
  endtask

  task automatic test_ready_at_timeout();
    issue(3'b010, OP_LD, 32'h0000_0304, 32'h0, 5'd6);
    for (int c = 1; c < TO; c++) tick();
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_ready = 1'b0;
    checks++; if (out_valid !== 1'b1 || bus_err !== 1'b0 || out_data !== 32'hCAFE_F00D || out_we !== 1'b1) begin
      failures++; $display("FAIL to_edge valid=%b err=%b data=%h we=%b exp=1/0/cafef00d/1", out_valid, bus_err, out_data, out_we); end
    tick();
  endtask

  task automatic test_reset_mid_req();
    issue(3'b010, OP_LD, 32'h0000_0300, 32'h0, 5'd6);
    tick(); tick(); tick();
    #2 reset = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++; $display("FAIL rst_mid req=%b valid=%b in_ready=%b exp=0/0/0", mem_req, out_valid, in_ready); end
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < TO + 4; c++) begin
      tick();
      checks++; if (out_valid !== 1'b0 || bus_err !== 1'b0 || mem_req !== 1'b0) begin
        failures++; $display("FAIL rst_quiet cycle=%0d valid=%b err=%b req=%b exp=0/0/0", c, out_valid, bus_err, mem_req); end
    end
    checks++; if (in_ready !== 1'b1) begin
      failures++; $display("FAIL rst_idle in_ready=%b exp=1", in_ready); end
  endtask

  task automatic test_misalign();
    issue(3'b010, OP_LD, 32'h0000_0102, 32'h0, 5'd8);
`ifdef MISALIGN_TRAP_EN
    checks++; if (mem_req !== 1'b0 || out_valid !== 1'b1 || misalign !== 1'b1 || out_we !== 1'b0 || out_data !== 32'h0) begin
      failures++; $display("FAIL mis_trap req=%b valid=%b mis=%b we=%b data=%h exp=0/1/1/0/0",
                           mem_req, out_valid, misalign, out_we, out_data); end
    tick();
`else
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
      failures++; $display("FAIL mis_word req=%b addr=%h exp=1/100", mem_req, mem_addr); end
    mem_ready = 1'b1; mem_rdata = 32'h0102_0304;
    tick();
    mem_ready = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h0102_0304 || misalign !== 1'b0) begin
      failures++; $display("FAIL mis_read valid=%b data=%h mis=%b exp=1/01020304/0", out_valid, out_data, misalign); end
    tick();
`endif
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_back_to_back();
    test_ignore_ready_idle();
    test_lb();
    test_lh();
    test_lhu();
    test_sb();
    test_sh();
    test_timeout();
    test_ready_at_timeout();
    test_reset_mid_req();
    test_misalign();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
